// File: rtl/xy_modulo_host_pkg.sv
// Shared definitions for the xy-modulo bus initiator.
//  - bus widths (16-bit write data, 32-bit readback, 2-bit address)
//  - peripheral register map (X, Y, result)
//  - FSM state encoding used by xy_modulo_host
//  - zext: zero-extends a data word to readback width for verify compares
package xy_modulo_host_pkg;

    localparam int DATA_W = 16;
    localparam int Q_W    = 32;
    localparam int ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_X   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_Y   = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_RES = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_X,
        ST_WR_Y,
        ST_SETTLE,
        ST_VF_X,
        ST_VF_XC,
        ST_VF_Y,
        ST_VF_YC,
        ST_RD_REQ,
        ST_RD_CAP,
        ST_FIN
    } state_t;

    function automatic logic [Q_W-1:0] zext(input logic [DATA_W-1:0] v);
        return {{(Q_W-DATA_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/xy_host_settle_cnt.sv
// Load/decrement counter timing the settle window after the operand writes.
// Ports:
//  clk, rst_n : clock, asynchronous active-low reset
//  load       : load load_val (takes priority over dec)
//  load_val   : value loaded; the window lasts load_val+1 cycles of dec
//  dec        : decrement while nonzero
//  zero       : count is zero (window has elapsed on this cycle)
module xy_host_settle_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/xy_modulo_host.sv
// Bus initiator for the xy-modulo peripheral. On an accepted start it writes
// X (addr 0) and Y (addr 1), waits SETTLE_CYCLES idle cycles, optionally reads
// X and Y back to check them, then reads the result (addr 2) and reports it
// with a one-cycle done pulse.
// Ports:
//  clk, rst_n        : clock, asynchronous active-low reset
//  start, x_in, y_in : request pulse and operands (accepted only when idle)
//  busy, done, err   : status; err is valid with done
//  result            : last result, held until the next done
//  bus_d/addr/w/r/e  : registered peripheral bus drive
//  bus_q             : peripheral readback, valid the cycle after a read strobe
module xy_modulo_host
    import xy_modulo_host_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int VERIFY        = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] y_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [Q_W-1:0]    result,
    output logic [DATA_W-1:0] bus_d,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_w,
    output logic              bus_r,
    output logic              bus_e,
    input  logic [Q_W-1:0]    bus_q
);

    localparam int CNT_W = 16;

    state_t            state_reg;
    logic [DATA_W-1:0] x_reg;
    logic [DATA_W-1:0] y_reg;
    logic              mismatch_reg;
    logic              settle_zero;

    // Counter is loaded while WR_Y is on the bus so it is primed on SETTLE entry.
    xy_host_settle_cnt #(.W(CNT_W)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_reg == ST_WR_Y),
        .load_val (CNT_W'(SETTLE_CYCLES - 1)),
        .dec      (state_reg == ST_SETTLE),
        .zero     (settle_zero)
    );

    // Outputs are registered alongside the state: each transition drives the
    // bus values belonging to the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            x_reg        <= '0;
            y_reg        <= '0;
            mismatch_reg <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            result       <= '0;
            bus_d        <= '0;
            bus_addr     <= '0;
            bus_w        <= 1'b0;
            bus_r        <= 1'b0;
            bus_e        <= 1'b0;
        end else begin
            // Strobes are single-cycle; data/address fall back to 0 without one.
            bus_w    <= 1'b0;
            bus_r    <= 1'b0;
            bus_d    <= '0;
            bus_addr <= '0;
            done     <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        x_reg        <= x_in;
                        y_reg        <= y_in;
                        mismatch_reg <= 1'b0;
                        busy         <= 1'b1;
                        bus_e        <= 1'b1;
                        if (x_in == y_in) begin
                            // X-Y would be zero: report without touching the bus.
                            state_reg <= ST_FIN;
                            done      <= 1'b1;
                            err       <= 1'b1;
                            result    <= '0;
                        end else begin
                            state_reg <= ST_WR_X;
                            bus_w     <= 1'b1;
                            bus_addr  <= ADDR_X;
                            bus_d     <= x_in;
                        end
                    end
                end
                ST_WR_X: begin
                    state_reg <= ST_WR_Y;
                    bus_w     <= 1'b1;
                    bus_addr  <= ADDR_Y;
                    bus_d     <= y_reg;
                end
                ST_WR_Y: begin
                    state_reg <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_zero) begin
                        bus_r <= 1'b1;
                        if (VERIFY != 0) begin
                            state_reg <= ST_VF_X;
                            bus_addr  <= ADDR_X;
                        end else begin
                            state_reg <= ST_RD_REQ;
                            bus_addr  <= ADDR_RES;
                        end
                    end
                end
                ST_VF_X: begin
                    state_reg <= ST_VF_XC;
                end
                ST_VF_XC: begin
                    if (bus_q != zext(x_reg)) begin
                        mismatch_reg <= 1'b1;
                    end
                    state_reg <= ST_VF_Y;
                    bus_r     <= 1'b1;
                    bus_addr  <= ADDR_Y;
                end
                ST_VF_Y: begin
                    state_reg <= ST_VF_YC;
                end
                ST_VF_YC: begin
                    if (bus_q != zext(y_reg)) begin
                        mismatch_reg <= 1'b1;
                    end
                    state_reg <= ST_RD_REQ;
                    bus_r     <= 1'b1;
                    bus_addr  <= ADDR_RES;
                end
                ST_RD_REQ: begin
                    state_reg <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    // A verify mismatch still delivers the fresh result.
                    result    <= bus_q;
                    err       <= mismatch_reg;
                    done      <= 1'b1;
                    state_reg <= ST_FIN;
                end
                ST_FIN: begin
                    busy      <= 1'b0;
                    bus_e     <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    bus_e     <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xy_modulo_host.sv
`timescale 1ns/100ps
module tb_xy_modulo_host;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #1 clk = ~clk;

    logic        start[2];
    logic [15:0] x_in[2];
    logic [15:0] y_in[2];
    logic        busy[2];
    logic        done[2];
    logic        err[2];
    logic [31:0] result[2];
    logic [15:0] bus_d[2];
    logic [1:0]  bus_addr[2];
    logic        bus_w[2];
    logic        bus_r[2];
    logic        bus_e[2];
    logic [31:0] bus_q[2];
    logic        inj_req[2];

    // Instance 0: plain, settle 1. Instance 1: verify on, settle 3.
    xy_modulo_host #(.SETTLE_CYCLES(1), .VERIFY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .x_in(x_in[0]), .y_in(y_in[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .result(result[0]),
        .bus_d(bus_d[0]), .bus_addr(bus_addr[0]), .bus_w(bus_w[0]), .bus_r(bus_r[0]),
        .bus_e(bus_e[0]), .bus_q(bus_q[0]));
    xy_modulo_host #(.SETTLE_CYCLES(3), .VERIFY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .x_in(x_in[1]), .y_in(y_in[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .result(result[1]),
        .bus_d(bus_d[1]), .bus_addr(bus_addr[1]), .bus_w(bus_w[1]), .bus_r(bus_r[1]),
        .bus_e(bus_e[1]), .bus_q(bus_q[1]));

    function automatic int s_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction
    function automatic int v_of(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, i, $time, act, exp);
        end
    endtask

    // ---------------- peripheral model ----------------
    logic [15:0] px[2];
    logic [15:0] py[2];
    logic        inj_txn[2];

    function automatic logic [31:0] xy_mod(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] diff;
        diff = x - y;
        return (diff == 16'd0) ? 32'd0 : {16'd0, x % diff};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (bus_e[i]) begin
                if (bus_w[i] && bus_addr[i] == 2'd0) px[i] <= bus_d[i];
                if (bus_w[i] && bus_addr[i] == 2'd1) py[i] <= bus_d[i];
                if (bus_r[i]) begin
                    case (bus_addr[i])
                        2'd0:    bus_q[i] <= {16'd0, px[i]} ^ (inj_txn[i] ? 32'h10 : 32'h0);
                        2'd1:    bus_q[i] <= {16'd0, py[i]};
                        2'd2:    bus_q[i] <= xy_mod(px[i], py[i]);
                        default: bus_q[i] <= 32'd0;
                    endcase
                end
            end
        end
    end

    // ---------------- behavioural reference ----------------
    int          cyc = 0;
    bit          has[2];
    int          p[2];
    int          lat[2];
    bit          eq[2];
    logic [15:0] mx[2];
    logic [15:0] my[2];
    logic [31:0] cur[2];
    logic [31:0] prev[2];
    logic        experr[2];

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                has[i] = 0; cur[i] = 0; prev[i] = 0; inj_txn[i] = 0;
            end else if (start[i] && (!has[i] || (cyc - p[i]) >= lat[i] + 1)) begin
                prev[i]    = cur[i];
                has[i]     = 1;
                p[i]       = cyc;
                mx[i]      = x_in[i];
                my[i]      = y_in[i];
                eq[i]      = (x_in[i] == y_in[i]);
                lat[i]     = eq[i] ? 1 : 5 + s_of(i) + 4 * v_of(i);
                inj_txn[i] = (v_of(i) == 1) && inj_req[i] && !eq[i];
                cur[i]     = eq[i] ? 32'd0 : xy_mod(x_in[i], y_in[i]);
                experr[i]  = eq[i] || inj_txn[i];
            end
        end
    end

    int          k;
    bit          act;
    int          s;
    int          v;
    logic        e_w, e_r, e_done;
    logic [1:0]  e_addr;
    logic [15:0] e_d;
    logic [31:0] e_res;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                chk("rst_busy", i, 32'(busy[i]), 32'd0);
                chk("rst_done", i, 32'(done[i]), 32'd0);
                chk("rst_err", i, 32'(err[i]), 32'd0);
                chk("rst_result", i, result[i], 32'd0);
                chk("rst_bus", i, {12'd0, bus_w[i], bus_r[i], bus_e[i], bus_addr[i], bus_d[i], 1'b0}, 32'd0);
            end else begin
                k = has[i] ? (cyc - p[i] + 1) : 0;
                act = has[i] && k >= 1 && k <= lat[i];
                s = s_of(i);
                v = v_of(i);
                e_w = 0; e_r = 0; e_addr = 0; e_d = 0;
                if (act && !eq[i]) begin
                    if (k == 1) begin e_w = 1; e_d = mx[i]; end
                    if (k == 2) begin e_w = 1; e_addr = 2'd1; e_d = my[i]; end
                    if (k == 3 + s) begin e_r = 1; e_addr = (v == 1) ? 2'd0 : 2'd2; end
                    if (v == 1 && k == 5 + s) begin e_r = 1; e_addr = 2'd1; end
                    if (v == 1 && k == 7 + s) begin e_r = 1; e_addr = 2'd2; end
                end
                e_done = act && (k == lat[i]);
                e_res = (has[i] && k >= lat[i]) ? cur[i] : prev[i];
                chk("busy", i, 32'(busy[i]), 32'(act));
                chk("bus_e", i, 32'(bus_e[i]), 32'(act));
                chk("done", i, 32'(done[i]), 32'(e_done));
                chk("bus_w", i, 32'(bus_w[i]), 32'(e_w));
                chk("bus_r", i, 32'(bus_r[i]), 32'(e_r));
                chk("bus_addr", i, 32'(bus_addr[i]), 32'(e_addr));
                chk("bus_d", i, 32'(bus_d[i]), 32'(e_d));
                chk("result", i, result[i], e_res);
                if (e_done) chk("err", i, 32'(err[i]), 32'(experr[i]));
            end
        end
    end

    // ---------------- directed transaction with literal expectations ----------------
    task automatic run_txn(input int i, input logic [15:0] x, input logic [15:0] y, input logic inj,
                           input int exp_lat, input logic [31:0] exp_res, input logic exp_err);
        int  n;
        bit  seen;
        @(posedge clk); #0.5;
        start[i] = 1; x_in[i] = x; y_in[i] = y; inj_req[i] = inj;
        @(posedge clk); #0.5;
        start[i] = 0; inj_req[i] = 0;
        seen = 0; n = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (done[i]) seen = 1;
        end
        chk("done_seen", i, 32'(seen), 32'd1);
        chk("latency", i, n, exp_lat);
        chk("lit_result", i, result[i], exp_res);
        chk("lit_err", i, 32'(err[i]), 32'(exp_err));
        $display("txn inst%0d x=%0d y=%0d -> result=%0d err=%0d latency=%0d", i, x, y, result[i], err[i], n);
        repeat (2) @(posedge clk);
    endtask

    int n_done;

    initial begin
        for (int i = 0; i < 2; i++) begin
            start[i] = 0; x_in[i] = 0; y_in[i] = 0; inj_req[i] = 0;
        end
        rst_n = 0;
        repeat (3) @(posedge clk);
        #0.5 rst_n = 1;
        @(negedge clk);
        chk("post_rst_busy", 0, 32'(busy[0]), 32'd0);
        chk("post_rst_result", 1, result[1], 32'd0);

        run_txn(0, 16'd8, 16'd4, 1'b0, 6, 32'd0, 1'b0);
        run_txn(0, 16'd100, 16'd1, 1'b0, 6, 32'd1, 1'b0);
        run_txn(0, 16'd65535, 16'd32000, 1'b0, 6, 32'd32000, 1'b0);
        run_txn(0, 16'd5, 16'd5, 1'b0, 1, 32'd0, 1'b1);
        run_txn(1, 16'd3, 16'd5, 1'b0, 12, 32'd3, 1'b0);
        run_txn(1, 16'd10, 16'd4, 1'b1, 12, 32'd4, 1'b1);

        // Extra start while busy, then reset during WR_Y.
        @(posedge clk); #0.5;
        start[0] = 1; x_in[0] = 16'd20; y_in[0] = 16'd7;
        @(posedge clk); #0.5;
        x_in[0] = 16'd9; y_in[0] = 16'd2;
        @(posedge clk); #0.5;
        start[0] = 0;
        rst_n = 0;
        @(negedge clk);
        chk("abort_busy", 0, 32'(busy[0]), 32'd0);
        chk("abort_bus_w", 0, 32'(bus_w[0]), 32'd0);
        chk("abort_bus_d", 0, 32'(bus_d[0]), 32'd0);
        repeat (2) @(posedge clk);
        #0.5 rst_n = 1;
        n_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done[0]) n_done++;
        end
        chk("no_done_after_rst", 0, n_done, 0);
        run_txn(0, 16'd20, 16'd7, 1'b0, 6, 32'd7, 1'b0);

        // Randomized traffic on both instances; the reference tracks acceptance.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #0.5;
            for (int i = 0; i < 2; i++) begin
                start[i] = ($urandom_range(0, 3) == 0);
                x_in[i] = 16'($urandom);
                case ($urandom_range(0, 7))
                    0: y_in[i] = x_in[i];
                    1: y_in[i] = x_in[i] + 16'd1;
                    2: y_in[i] = 16'($urandom_range(0, 20));
                    default: y_in[i] = 16'($urandom);
                endcase
                inj_req[i] = ($urandom_range(0, 2) == 0);
            end
        end
        @(posedge clk); #0.5;
        for (int i = 0; i < 2; i++) begin
            start[i] = 0; inj_req[i] = 0;
        end
        repeat (30) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
